k_alu_ctrl_issue: RTL and testbench

ALU control and issue stage sitting directly upstream of the K_ALU datapath. It accepts decoded instruction fields and register operands from the ID side over a valid/ready handshake. It translates ALUOp/funct into the 4-bit ALU control code and buffers up to two issue entries. It presents the head entry (control code plus both operands) to the ALU, and also keeps a sticky illegal-funct flag and a wrap-around issue counter.

---
 rtl/k_alu_ctrl_issue.sv | 174 +++++++++++++++++
 tb/tb_k_alu_ctrl_issue.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k_alu_ctrl_issue.sv
// k_alu_ctrl_issue
//   ALU control and issue stage in front of the K_ALU datapath. Entries from
//   the ID side are decoded (ALUOp/funct -> 4-bit ALU control) when they are
//   pushed, then held in a 2-entry FIFO. The head entry is presented to the
//   ALU. A sticky illegal-funct flag and a wrapping count of legal issues
//   are also kept.
//
// Ports
//   K_clk, K_rst_n              clock, asynchronous active-low reset
//   K_flush                     synchronous clear of the buffer
//   K_in_valid / K_in_ready     upstream handshake
//   K_alu_op, K_funct           decode inputs
//   K_op_a, K_op_b, K_tag       operands and destination tag
//   K_out_valid / K_out_ready   ALU-side handshake for the head entry
//   K_ALU_control, K_alu_in1,
//   K_alu_in2, K_out_tag,
//   K_out_illegal               head entry fields (zero while empty)
//   K_illegal_seen              sticky, set by any illegal push
//   K_issue_count               legal pops, wraps at 2^CNT_W
module k_alu_ctrl_issue #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             K_clk,
  input  logic             K_rst_n,
  input  logic             K_flush,
  input  logic             K_in_valid,
  output logic             K_in_ready,
  input  logic [1:0]       K_alu_op,
  input  logic [5:0]       K_funct,
  input  logic [W-1:0]     K_op_a,
  input  logic [W-1:0]     K_op_b,
  input  logic [4:0]       K_tag,
  output logic             K_out_valid,
  input  logic             K_out_ready,
  output logic [3:0]       K_ALU_control,
  output logic [W-1:0]     K_alu_in1,
  output logic [W-1:0]     K_alu_in2,
  output logic [4:0]       K_out_tag,
  output logic             K_out_illegal,
  output logic             K_illegal_seen,
  output logic [CNT_W-1:0] K_issue_count
);

  typedef struct packed {
    logic         ill;
    logic [4:0]   tag;
    logic [W-1:0] b;
    logic [W-1:0] a;
    logic [3:0]   ctrl;
  } entry_t;

  logic [1:0]       occ_q, occ_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             illegal_seen_q, illegal_seen_d;
  logic [CNT_W-1:0] issue_count_q, issue_count_d;

  logic [3:0] dec_ctrl;
  logic       dec_ill;
  logic       push;
  logic       pop;
  entry_t     new_entry;
  entry_t     head;
  entry_t     slot_rd [2];
  logic [1:0] slot_we;

  // ALUOp/funct translation, done once at push time.
  always_comb begin
    dec_ctrl = 4'b0010;
    dec_ill  = 1'b0;
    case (K_alu_op)
      2'b00: dec_ctrl = 4'b0010;
      2'b01: dec_ctrl = 4'b0110;
      2'b11: dec_ctrl = 4'b0001;
      default: begin
        case (K_funct)
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0110;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b101010: dec_ctrl = 4'b0111;
          default: begin
            dec_ctrl = 4'b0010;
            dec_ill  = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign new_entry = '{ill: dec_ill, tag: K_tag, b: K_op_b, a: K_op_a, ctrl: dec_ctrl};

  // Handshake flags come only from registered occupancy, so a pop never
  // opens a slot for a push in the same cycle.
  assign K_in_ready  = (occ_q < 2'd2);
  assign K_out_valid = (occ_q != 2'd0);
  assign push        = K_in_valid & K_in_ready;
  assign pop         = K_out_valid & K_out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      entry_t slot_q, slot_d;

      // A flushed push is dropped, so it never lands in storage.
      assign slot_we[gi] = push & ~K_flush & (wr_ptr_q == 1'(gi));

      always_comb begin
        slot_d = slot_q;
        if (slot_we[gi]) slot_d = new_entry;
      end

      always_ff @(posedge K_clk or negedge K_rst_n) begin
        if (!K_rst_n) slot_q <= '0;
        else          slot_q <= slot_d;
      end

      assign slot_rd[gi] = slot_q;
    end
  endgenerate

  // Empty buffer presents all-zero head fields, also after flush or drain.
  assign head = K_out_valid ? slot_rd[rd_ptr_q] : '0;

  always_comb begin
    occ_d          = occ_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    illegal_seen_d = illegal_seen_q;
    issue_count_d  = issue_count_q;
    if (K_flush) begin
      // Same-cycle push and pop are both discarded; the sticky flag stays.
      occ_d    = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
        if (dec_ill) illegal_seen_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        if (!head.ill) issue_count_d = issue_count_q + CNT_W'(1);
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge K_clk or negedge K_rst_n) begin
    if (!K_rst_n) begin
      occ_q          <= 2'd0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      illegal_seen_q <= 1'b0;
      issue_count_q  <= '0;
    end else begin
      occ_q          <= occ_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      illegal_seen_q <= illegal_seen_d;
      issue_count_q  <= issue_count_d;
    end
  end

  assign K_ALU_control  = head.ctrl;
  assign K_alu_in1      = head.a;
  assign K_alu_in2      = head.b;
  assign K_out_tag      = head.tag;
  assign K_out_illegal  = head.ill;
  assign K_illegal_seen = illegal_seen_q;
  assign K_issue_count  = issue_count_q;

endmodule

// File: tb/tb_k_alu_ctrl_issue.sv
// Bench for k_alu_ctrl_issue: decode vector table, hand-written handshake
// sequences, randomized traffic against a queue-based reference model, and
// the issue-counter wrap.
module tb_k_alu_ctrl_issue;
  localparam int W     = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [4:0]       tag;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       alu_ctrl;
  logic [W-1:0]     in1;
  logic [W-1:0]     in2;
  logic [4:0]       out_tag;
  logic             out_ill;
  logic             ill_seen;
  logic [CNT_W-1:0] cnt;

  int total = 0;
  int bad   = 0;

  k_alu_ctrl_issue #(.W(W), .CNT_W(CNT_W)) dut (
    .K_clk(clk), .K_rst_n(rst_n), .K_flush(flush),
    .K_in_valid(in_valid), .K_in_ready(in_ready),
    .K_alu_op(alu_op), .K_funct(funct), .K_op_a(op_a), .K_op_b(op_b), .K_tag(tag),
    .K_out_valid(out_valid), .K_out_ready(out_ready),
    .K_ALU_control(alu_ctrl), .K_alu_in1(in1), .K_alu_in2(in2),
    .K_out_tag(out_tag), .K_out_illegal(out_ill),
    .K_illegal_seen(ill_seen), .K_issue_count(cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   tag;
    logic         ill;
  } ent_t;

  ent_t             mq[$];
  logic [CNT_W-1:0] m_cnt;
  bit               m_seen;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] fn,
                                     output logic [3:0] c, output logic il);
    il = 1'b0;
    if (op == 2'b00) c = 4'b0010;
    else if (op == 2'b01) c = 4'b0110;
    else if (op == 2'b11) c = 4'b0001;
    else begin
      case (fn)
        6'b100000: c = 4'b0010;
        6'b100010: c = 4'b0110;
        6'b100100: c = 4'b0000;
        6'b100101: c = 4'b0001;
        6'b101010: c = 4'b0111;
        default: begin c = 4'b0010; il = 1'b1; end
      endcase
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_cnt  = '0;
    m_seen = 1'b0;
  endfunction

  function automatic void model_step(bit fl, bit iv, bit ordy, logic [1:0] op,
                                     logic [5:0] fn, logic [W-1:0] a, logic [W-1:0] b,
                                     logic [4:0] tg);
    bit   push_ok, pop_ok;
    ent_t e, p;
    push_ok = iv && (mq.size() < 2);
    pop_ok  = ordy && (mq.size() > 0);
    if (fl) begin
      mq.delete();
    end else begin
      if (pop_ok) begin
        p = mq.pop_front();
        if (!p.ill) m_cnt = m_cnt + 1'b1;
      end
      if (push_ok) begin
        ref_decode(op, fn, e.ctrl, e.ill);
        e.a = a; e.b = b; e.tag = tg;
        mq.push_back(e);
        if (e.ill) m_seen = 1'b1;
      end
    end
  endfunction

  task automatic model_check(string pfx);
    chk({pfx, ".in_ready"},  64'(in_ready),  64'(mq.size() < 2));
    chk({pfx, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk({pfx, ".ctrl"}, 64'(alu_ctrl), 64'(mq[0].ctrl));
      chk({pfx, ".in1"},  64'(in1),      64'(mq[0].a));
      chk({pfx, ".in2"},  64'(in2),      64'(mq[0].b));
      chk({pfx, ".tag"},  64'(out_tag),  64'(mq[0].tag));
      chk({pfx, ".ill"},  64'(out_ill),  64'(mq[0].ill));
    end
    chk({pfx, ".seen"}, 64'(ill_seen), 64'(m_seen));
    chk({pfx, ".cnt"},  64'(cnt),      64'(m_cnt));
  endtask

  // Drive one cycle from a negedge, advance the model, land on the next negedge.
  task automatic cyc(bit fl, bit iv, bit ordy, logic [1:0] op, logic [5:0] fn,
                     logic [W-1:0] a, logic [W-1:0] b, logic [4:0] tg);
    flush = fl; in_valid = iv; out_ready = ordy;
    alu_op = op; funct = fn; op_a = a; op_b = b; tag = tg;
    model_step(fl, iv, ordy, op, fn, a, b, tg);
    @(negedge clk);
  endtask

  task automatic do_reset();
    flush = 0; in_valid = 0; out_ready = 0;
    alu_op = 0; funct = 0; op_a = 0; op_b = 0; tag = 0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(string pfx);
    chk({pfx, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({pfx, ".in_ready"},  64'(in_ready),  64'd1);
    chk({pfx, ".ctrl"},      64'(alu_ctrl),  64'd0);
    chk({pfx, ".in1"},       64'(in1),       64'd0);
    chk({pfx, ".in2"},       64'(in2),       64'd0);
    chk({pfx, ".tag"},       64'(out_tag),   64'd0);
    chk({pfx, ".ill"},       64'(out_ill),   64'd0);
    chk({pfx, ".seen"},      64'(ill_seen),  64'd0);
    chk({pfx, ".cnt"},       64'(cnt),       64'd0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] exp_ctrl;
    logic       exp_ill;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [CNT_W-1:0] c0;

    vecs[0] = '{2'b00, 6'b101010, 4'b0010, 1'b0};
    vecs[1] = '{2'b01, 6'b000000, 4'b0110, 1'b0};
    vecs[2] = '{2'b11, 6'b111111, 4'b0001, 1'b0};
    vecs[3] = '{2'b10, 6'b100000, 4'b0010, 1'b0};
    vecs[4] = '{2'b10, 6'b100010, 4'b0110, 1'b0};
    vecs[5] = '{2'b10, 6'b100100, 4'b0000, 1'b0};
    vecs[6] = '{2'b10, 6'b100101, 4'b0001, 1'b0};
    vecs[7] = '{2'b10, 6'b101010, 4'b0111, 1'b0};
    vecs[8] = '{2'b10, 6'b111111, 4'b0010, 1'b1};

    // Reset values.
    do_reset();
    chk_reset_vals("reset");

    // Single push, visible the cycle after, then popped and counted.
    cyc(0, 1, 1, 2'b10, 6'b100010, 9, 4, 3);
    $display("push sub a=9 b=4 tag=3");
    chk("t1.valid", 64'(out_valid), 64'd1);
    chk("t1.ctrl",  64'(alu_ctrl),  64'h6);
    chk("t1.in1",   64'(in1),       64'd9);
    chk("t1.in2",   64'(in2),       64'd4);
    chk("t1.tag",   64'(out_tag),   64'd3);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    chk("t1.cnt",   64'(cnt),       64'd1);
    chk("t1.empty", 64'(out_valid), 64'd0);

    // Back-pressure: three pushes, only two accepted, ordered drain.
    cyc(0, 1, 0, 2'b00, 0, 100, 1, 1);
    cyc(0, 1, 0, 2'b01, 0, 200, 2, 2);
    chk("bp.ready_full", 64'(in_ready), 64'd0);
    chk("bp.head1",      64'(out_tag),  64'd1);
    cyc(0, 1, 0, 2'b11, 0, 300, 3, 3);
    chk("bp.held_ready", 64'(in_ready), 64'd0);
    chk("bp.head1_hold", 64'(out_tag),  64'd1);
    chk("bp.in1_hold",   64'(in1),      64'd100);
    cyc(0, 1, 1, 2'b11, 0, 300, 3, 3);
    $display("pop tag=1");
    chk("bp.head2",      64'(out_tag),  64'd2);
    chk("bp.ready_back", 64'(in_ready), 64'd1);
    cyc(0, 1, 1, 2'b11, 0, 300, 3, 3);
    $display("pop tag=2 push tag=3");
    chk("bp.head3",      64'(out_tag),  64'd3);
    chk("bp.ctrl3",      64'(alu_ctrl), 64'h1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    $display("pop tag=3");
    chk("bp.drained",    64'(out_valid), 64'd0);
    chk("bp.cnt",        64'(cnt),       64'd4);

    // Illegal funct.
    cyc(0, 1, 0, 2'b10, 6'b000000, 5, 6, 7);
    $display("push illegal funct");
    chk("ill.out_ill", 64'(out_ill),  64'd1);
    chk("ill.ctrl",    64'(alu_ctrl), 64'h2);
    chk("ill.seen",    64'(ill_seen), 64'd1);
    c0 = cnt;
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    chk("ill.cnt_held", 64'(cnt), 64'(c0));

    // Simultaneous push/pop at occupancy 1.
    do_reset();
    cyc(0, 1, 0, 2'b00, 0, 1000, 0, 10);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1, 2'b00, 0, W'(1001 + i), 0, 5'(11 + i));
      $display("push/pop cycle %0d head tag=%0d", i, out_tag);
      chk("pp.valid", 64'(out_valid), 64'd1);
      chk("pp.tag",   64'(out_tag),   64'(11 + i));
    end
    chk("pp.cnt", 64'(cnt), 64'd5);

    // Flush with two entries, a blocked push and a pop in the same cycle.
    cyc(0, 1, 0, 2'b10, 6'b001111, 1, 1, 20);
    cyc(0, 1, 0, 2'b00, 0, 2, 2, 21);
    chk("fl.full", 64'(in_ready), 64'd0);
    cyc(1, 1, 1, 2'b00, 0, 3, 3, 22);
    $display("flush with 2 entries");
    chk("fl.valid", 64'(out_valid), 64'd0);
    chk("fl.ready", 64'(in_ready),  64'd1);
    chk("fl.seen",  64'(ill_seen),  64'd1);
    chk("fl.cnt",   64'(cnt),       64'd5);
    chk("fl.tag",   64'(out_tag),   64'd0);

    // Asynchronous reset between edges with two entries buffered.
    cyc(0, 1, 0, 2'b01, 0, 7, 8, 9);
    cyc(0, 1, 0, 2'b01, 0, 7, 8, 9);
    in_valid = 0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset mid-cycle");
    chk_reset_vals("arst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    // Decode table.
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 0, vecs[i].op, vecs[i].fn, W'(i), W'(i * 3), 5'(i));
      $display("decode op=%b funct=%b ctrl=%b ill=%b", vecs[i].op, vecs[i].fn, alu_ctrl, out_ill);
      chk("dec.ctrl", 64'(alu_ctrl), 64'(vecs[i].exp_ctrl));
      chk("dec.ill",  64'(out_ill),  64'(vecs[i].exp_ill));
      cyc(0, 0, 1, 0, 0, 0, 0, 0);
    end
    model_check("dec.end");

    // Randomized traffic against the model.
    do_reset();
    model_check("rnd.start");
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] fn;
      case ($urandom_range(0, 5))
        0: fn = 6'b100000;
        1: fn = 6'b100010;
        2: fn = 6'b100100;
        3: fn = 6'b100101;
        4: fn = 6'b101010;
        default: fn = 6'($urandom);
      endcase
      cyc(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
          2'($urandom), fn, $urandom, $urandom, 5'($urandom));
      model_check("rnd");
    end
    $display("random phase done cnt=%0d", cnt);

    // Counter wrap: 65535 legal pops, then one more.
    do_reset();
    for (int n = 0; n < 65535; n++) cyc(0, 1, 1, 2'b00, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    $display("after 65535 pops cnt=%0h", cnt);
    chk("wrap.max", 64'(cnt), 64'hFFFF);
    cyc(0, 1, 1, 2'b00, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    $display("after one more pop cnt=%0h", cnt);
    chk("wrap.zero", 64'(cnt), 64'd0);
    model_check("wrap.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
